// File: rtl/y86_pkg.sv
// ============================================================================
//  Module : y86_pkg
//  Brief  : Shared Y86-64 constants for the memory stage.
//           These are the stat codes, the icodes and the access FSM state codes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_bytes.sv
// ============================================================================
//  Module : dmem_bytes
//  Brief  : Byte-addressed data memory with one little-endian word-wide port.
//           Reads are combinational, writes happen on the clock edge, and there is no reset.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_bytes #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // Byte-by-byte assembly also serves unaligned addresses
    always_comb begin
        rdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata[8*i +: 8] = mem[addr + ADDR_W'(i)];
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_stage_pipe.sv
// ============================================================================
//  Module : memory_stage_pipe
//  Brief  : Y86-64 memory stage. It contains the M pipeline register, the data
//           memory and a multi-cycle access FSM. Define DMEM_ALIGN_CHECK_EN to
//           make misaligned accesses report an address error.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_stage_pipe
    import y86_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 2048,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_stall,
    input  logic              M_bubble,
    input  logic [3:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic              e_cnd,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [DATA_W-1:0] e_valE,
    output logic [3:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic              m_cnd,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic [DATA_W-1:0] m_valE,
    output logic [DATA_W-1:0] m_valM,
    output logic              m_busy,
    output logic              dmem_error
);

    localparam int                BYTES        = DATA_W / 8;
    localparam int                ADDR_W       = $clog2(DEPTH_BYTES);
    localparam logic [DATA_W-1:0] C_LAST_ADDR  = DATA_W'(DEPTH_BYTES - BYTES);
    localparam logic [DATA_W-1:0] C_ALIGN_MASK = DATA_W'(BYTES - 1);

    function automatic logic is_wr(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
    endfunction

    function automatic logic is_rd(input logic [3:0] ic);
        return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
    endfunction

    function automatic logic [DATA_W-1:0] sel_addr(input logic [3:0] ic,
                                                   input logic [DATA_W-1:0] va,
                                                   input logic [DATA_W-1:0] ve);
        return ((ic == I_RET) || (ic == I_POPQ)) ? va : ve;
    endfunction

    function automatic logic addr_bad(input logic [DATA_W-1:0] a);
        logic bad;
        bad = (a > C_LAST_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
        bad = bad | ((a & C_ALIGN_MASK) != '0);
`endif
        return bad;
    endfunction

    logic [3:0]        r_stat, r_icode, r_dstE, r_dstM;
    logic              r_cnd;
    logic [DATA_W-1:0] r_valA, r_valE;

    logic              w_mem_op, w_err, w_valid, w_busy, w_access, w_load;
    logic [DATA_W-1:0] w_addr, w_rdata;

    assign w_mem_op = is_wr(r_icode) | is_rd(r_icode);
    assign w_addr   = sel_addr(r_icode, r_valA, r_valE);
    assign w_err    = w_mem_op & addr_bad(w_addr);
    assign w_valid  = w_mem_op & ~w_err & (r_stat == STAT_AOK);
    assign w_load   = ~(M_stall | w_busy) & ~M_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_valA  <= '0;
            r_valE  <= '0;
        end else if (M_stall | w_busy) begin
            r_stat  <= r_stat;
        end else if (M_bubble) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_valA  <= '0;
            r_valE  <= '0;
        end else begin
            r_stat  <= e_stat;
            r_icode <= e_icode;
            r_cnd   <= e_cnd;
            r_dstE  <= e_dstE;
            r_dstM  <= e_dstM;
            r_valA  <= e_valA;
            r_valE  <= e_valE;
        end
    end

    generate
        if (MEM_LAT > 1) begin : g_multi
            localparam int CNT_W = $clog2(MEM_LAT);

            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             w_e_valid;

            // The state tracks the op being loaded, so its first M cycle is already a wait cycle
            assign w_e_valid = (is_wr(e_icode) | is_rd(e_icode)) & (e_stat == STAT_AOK)
                             & ~addr_bad(sel_addr(e_icode, e_valA, e_valE));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else if (r_state == ST_WAIT) begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                end else if (w_load && w_e_valid) begin
                    r_state <= ST_WAIT;
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                end else if (M_stall) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= ST_IDLE;
                end
            end

            assign w_busy   = (r_state == ST_WAIT);
            assign w_access = w_valid & ~w_busy;
        end else begin : g_single
            assign w_busy   = 1'b0;
            assign w_access = w_valid;
        end
    endgenerate

    dmem_bytes #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .we    (w_access & is_wr(r_icode)),
        .addr  (w_addr[ADDR_W-1:0]),
        .wdata (r_valA),
        .rdata (w_rdata)
    );

    assign m_stat     = w_err ? STAT_ADR : r_stat;
    assign m_icode    = r_icode;
    assign m_cnd      = r_cnd;
    assign m_dstE     = r_dstE;
    assign m_dstM     = r_dstM;
    assign m_valE     = r_valE;
    assign m_valM     = (w_access & is_rd(r_icode)) ? w_rdata : '0;
    assign m_busy     = w_busy;
    assign dmem_error = w_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage_pipe.sv
// ============================================================================
//  Module : tb_memory_stage_pipe
//  Brief  : Self-checking bench. It drives two DUT instances (MEM_LAT=1 and
//           MEM_LAT=3) against a byte-array reference memory.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_stage_pipe;
    import y86_pkg::*;

    localparam int DEPTH = 2048;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        M_stall [2], M_bubble [2], e_cnd [2];
    logic [3:0]  e_stat [2], e_icode [2], e_dstE [2], e_dstM [2];
    logic [63:0] e_valA [2], e_valE [2];
    logic [3:0]  m_stat [2], m_icode [2], m_dstE [2], m_dstM [2];
    logic        m_cnd [2], m_busy [2], dmem_error [2];
    logic [63:0] m_valE [2], m_valM [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        memory_stage_pipe #(.DATA_W(64), .DEPTH_BYTES(DEPTH), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .M_stall(M_stall[g]), .M_bubble(M_bubble[g]),
            .e_stat(e_stat[g]), .e_icode(e_icode[g]), .e_cnd(e_cnd[g]), .e_dstE(e_dstE[g]),
            .e_dstM(e_dstM[g]), .e_valA(e_valA[g]), .e_valE(e_valE[g]),
            .m_stat(m_stat[g]), .m_icode(m_icode[g]), .m_cnd(m_cnd[g]), .m_dstE(m_dstE[g]),
            .m_dstM(m_dstM[g]), .m_valE(m_valE[g]), .m_valM(m_valM[g]), .m_busy(m_busy[g]),
            .dmem_error(dmem_error[g]));
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] model [2][DEPTH];

    typedef struct {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] va;
        logic [63:0] ve;
        logic        xerr;
        logic [3:0]  xstat;
        logic [63:0] xvalM;
    } vec_t;
    vec_t tbl [14];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit m_wr(input logic [3:0] ic);
        return ic == 4'd4 || ic == 4'd8 || ic == 4'd10;
    endfunction

    function automatic bit m_rd(input logic [3:0] ic);
        return ic == 4'd5 || ic == 4'd9 || ic == 4'd11;
    endfunction

    function automatic logic [63:0] m_addr(input logic [3:0] ic, input logic [63:0] va, ve);
        return (ic == 4'd9 || ic == 4'd11) ? va : ve;
    endfunction

    function automatic bit m_bad(input logic [63:0] a);
        return (a > 64'(DEPTH - 8)) || (ALN && a[2:0] != 3'd0);
    endfunction

    function automatic logic [63:0] mread(input int k, input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = model[k][int'(a[10:0]) + i];
        return v;
    endfunction

    task automatic mwrite(input int k, input logic [3:0] st, ic, input logic [63:0] va, ve);
        logic [63:0] a;
        a = m_addr(ic, va, ve);
        if (m_wr(ic) && st == STAT_AOK && !m_bad(a))
            for (int i = 0; i < 8; i++) model[k][int'(a[10:0]) + i] = va[8*i +: 8];
    endtask

    task automatic chk(input string nm, input int k, input logic [63:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lat=%0d: got %h want %h", nm, lat_of(k), act, exp);
        end
    endtask

    task automatic idle_in(input int k);
        M_stall[k] = 1'b0; M_bubble[k] = 1'b0; e_stat[k] = STAT_AOK; e_icode[k] = I_NOP;
        e_cnd[k] = 1'b0; e_dstE[k] = RNONE; e_dstM[k] = RNONE; e_valA[k] = '0; e_valE[k] = '0;
    endtask

    task automatic set_op(input int k, input logic [3:0] st, ic, input logic [63:0] va, ve);
        e_stat[k] = st; e_icode[k] = ic; e_cnd[k] = 1'b1; e_dstE[k] = 4'd7; e_dstM[k] = 4'd3;
        e_valA[k] = va; e_valE[k] = ve;
    endtask

    // One op through M, checked in its completion cycle; caller updates the model
    task automatic issue(input int k, input logic [3:0] st, ic, input logic [63:0] va, ve,
                         input logic xerr, input logic [3:0] xstat, input logic [63:0] xvalM);
        int cyc, busy_n, xbusy;
        xbusy = (m_wr(ic) || m_rd(ic)) && !xerr && st == STAT_AOK ? lat_of(k) - 1 : 0;
        set_op(k, st, ic, va, ve);
        @(posedge clk); #1;
        idle_in(k);
        cyc = 0; busy_n = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (!m_busy[k]) break;
            busy_n++; cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 20) chk("timeout", k, 64'd1, 64'd0);
        chk("dmem_error", k, 64'(dmem_error[k]), 64'(xerr));
        chk("m_stat", k, 64'(m_stat[k]), 64'(xstat));
        chk("m_valM", k, m_valM[k], xvalM);
        chk("busy_cycles", k, 64'(busy_n), 64'(xbusy));
        chk("m_icode", k, 64'(m_icode[k]), 64'(ic));
        chk("m_valE", k, m_valE[k], ve);
        @(posedge clk); #1;
    endtask

    task automatic issue_model(input int k, input logic [3:0] st, ic, input logic [63:0] va, ve);
        logic [63:0] a, xv;
        logic        e;
        a  = m_addr(ic, va, ve);
        e  = (m_wr(ic) || m_rd(ic)) && m_bad(a);
        xv = (m_rd(ic) && !e && st == STAT_AOK) ? mread(k, a) : 64'd0;
        issue(k, st, ic, va, ve, e, e ? STAT_ADR : st, xv);
        mwrite(k, st, ic, va, ve);
    endtask

    task automatic run_suite(input int k);
        int cyc;
        logic [63:0] a, d;
        logic [3:0]  ic, st;
        logic [3:0]  icl [10];
        icl = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd6, 4'd1, 4'd2, 4'd7};

        rst_n[k] = 1'b0; idle_in(k);
        #1;
        chk("rst_icode", k, 64'(m_icode[k]), 64'(I_NOP));
        chk("rst_stat", k, 64'(m_stat[k]), 64'(STAT_AOK));
        chk("rst_dst", k, 64'({m_dstE[k], m_dstM[k]}), 64'h00FF);
        chk("rst_busy_valM", k, 64'({m_busy[k], dmem_error[k]}) | m_valM[k], 64'd0);
        @(posedge clk); @(negedge clk); rst_n[k] = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            issue(k, tbl[i].stat, tbl[i].icode, tbl[i].va, tbl[i].ve,
                  tbl[i].xerr, tbl[i].xstat, tbl[i].xvalM);
            mwrite(k, tbl[i].stat, tbl[i].icode, tbl[i].va, tbl[i].ve);
        end

        // Prefill the region used by random accesses
        for (int i = 0; i < 9; i++)
            issue_model(k, STAT_AOK, I_RMMOVQ, {$urandom, $urandom}, (i == 8) ? 64'd2040 : 64'(8 * i));

        issue_model(k, STAT_AOK, I_MRMOVQ, 64'd0, 64'd3);

        // Back-to-back write then read of the same word
        d = {$urandom, $urandom};
        set_op(k, STAT_AOK, I_RMMOVQ, d, 64'd24);
        @(posedge clk); #1;
        set_op(k, STAT_AOK, I_MRMOVQ, 64'd0, 64'd24);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (m_icode[k] == I_MRMOVQ && !m_busy[k]) break;
            cyc++;
            @(posedge clk); #1;
        end
        chk("raw_valM", k, m_valM[k], (cyc < 20) ? d : ~d);
        mwrite(k, STAT_AOK, I_RMMOVQ, d, 64'd24);
        idle_in(k);
        @(posedge clk); #1;

        // Stall wins over bubble, then bubble alone inserts a NOP
        set_op(k, STAT_AOK, I_MRMOVQ, 64'd0, 64'd8);
        @(posedge clk); #1;
        idle_in(k); e_icode[k] = 4'd6; M_stall[k] = 1'b1; M_bubble[k] = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (!m_busy[k]) break;
            cyc++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold", k, {52'd0, m_icode[k], m_dstM[k], m_dstE[k]}, {52'd0, I_MRMOVQ, 4'd3, 4'd7});
        chk("stall_valE", k, m_valE[k], 64'd8);
        M_stall[k] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_nop", k, {52'd0, m_icode[k], m_dstM[k], m_dstE[k]}, {52'd0, I_NOP, RNONE, RNONE});
        idle_in(k);
        @(posedge clk); #1;

        if (lat_of(k) > 1) begin
            issue_model(k, STAT_AOK, I_RMMOVQ, 64'h77, 64'd0);
            set_op(k, STAT_AOK, I_RMMOVQ, 64'd5, 64'd0);
            @(posedge clk); #1;
            idle_in(k);
            chk("wait_busy", k, 64'(m_busy[k]), 64'd1);
            #1 rst_n[k] = 1'b0;
            #1;
            chk("abort_busy", k, 64'(m_busy[k]), 64'd0);
            chk("abort_icode", k, 64'(m_icode[k]), 64'(I_NOP));
            @(posedge clk); @(negedge clk); rst_n[k] = 1'b1;
            @(posedge clk); #1;
            issue_model(k, STAT_AOK, I_MRMOVQ, 64'd0, 64'd0);
        end

        for (int n = 0; n < 60; n++) begin
            ic = icl[$urandom_range(0, 9)];
            st = ($urandom_range(0, 7) == 0) ? STAT_HLT : STAT_AOK;
            case ($urandom_range(0, 9))
                8:       a = 64'd2041 + 64'($urandom_range(0, 6));
                9:       a = 64'd2040;
                default: a = 64'($urandom_range(0, 56));
            endcase
            d = {$urandom, $urandom};
            if (ic == 4'd9 || ic == 4'd11) issue_model(k, st, ic, a, d);
            else                           issue_model(k, st, ic, d, a);
        end
    endtask

    initial begin
        tbl[0]  = '{STAT_AOK, I_RMMOVQ, 64'd66, 64'd62, ALN, ALN ? STAT_ADR : STAT_AOK, 64'd0};
        tbl[1]  = '{STAT_AOK, I_MRMOVQ, 64'd0, 64'd62, ALN, ALN ? STAT_ADR : STAT_AOK, ALN ? 64'd0 : 64'd66};
        tbl[2]  = '{STAT_AOK, I_RMMOVQ, 64'h1122334455667788, 64'd0, 1'b0, STAT_AOK, 64'd0};
        tbl[3]  = '{STAT_AOK, I_MRMOVQ, 64'd0, 64'd0, 1'b0, STAT_AOK, 64'h1122334455667788};
        tbl[4]  = '{STAT_AOK, I_PUSHQ, 64'd33, 64'd2041, 1'b1, STAT_ADR, 64'd0};
        tbl[5]  = '{STAT_AOK, I_PUSHQ, 64'hAB, 64'd2040, 1'b0, STAT_AOK, 64'd0};
        tbl[6]  = '{STAT_AOK, I_POPQ, 64'd2040, 64'd0, 1'b0, STAT_AOK, 64'hAB};
        tbl[7]  = '{STAT_AOK, I_CALL, 64'h400, 64'd16, 1'b0, STAT_AOK, 64'd0};
        tbl[8]  = '{STAT_AOK, I_RET, 64'd16, 64'd24, 1'b0, STAT_AOK, 64'h400};
        tbl[9]  = '{STAT_AOK, 4'd6, 64'd0, 64'd2, 1'b0, STAT_AOK, 64'd0};
        tbl[10] = '{STAT_HLT, I_RMMOVQ, 64'd99, 64'd0, 1'b0, STAT_HLT, 64'd0};
        tbl[11] = '{STAT_AOK, I_MRMOVQ, 64'd0, 64'd0, 1'b0, STAT_AOK, 64'h1122334455667788};
        tbl[12] = '{STAT_AOK, I_MRMOVQ, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, STAT_ADR, 64'd0};
        tbl[13] = '{STAT_AOK, I_NOP, 64'd5, 64'd6, 1'b0, STAT_AOK, 64'd0};
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            idle_in(k);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) run_suite(k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
